inst_cache: RTL and testbench
=============================

Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache serving the fetch stage.
- It is the responder on the fetch request interface. Fetch presents a PC and this block returns the instruction word together with a hit flag.
- On a miss it runs a line-refill FSM against a word-serial backing instruction memory. The fetch stage stalls while hit_out is low.

Parameters:
- LINES, 16: number of cache lines; power of 2, minimum 2.
- WORDS, 4: 32-bit words per line; power of 2, minimum 2.
- Derived constants:
  - OB = log2(WORDS)
  - IB = log2(LINES)
  - TAGW = 32 - 2 - OB - IB

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch is presenting a valid PC this cycle.
- req_addr  in  32  fetch PC, byte address; bits [1:0] are ignored.
- flush  in  1  invalidate all lines (e.g. after self-modifying code load).
- hit_out  out  1  instruction_out is valid for req_addr this cycle.
- instruction_out  out  32  instruction word for req_addr when hit_out=1, else 0.
- busy  out  1  refill in progress.
- mem_req  out  1  read request to backing memory.
- mem_addr  out  32  word-aligned read address; bits [1:0] are always 0.
- mem_rdata  in  32  backing memory read data.
- mem_valid  in  1  mem_rdata is valid; completes the outstanding mem_req.

Behaviour:
- Address split:
  - word = req_addr[2+OB-1:2]
  - index = req_addr[2+OB+IB-1:2+OB]
  - tag = req_addr[31:2+OB+IB]
- Storage per line: valid bit, tag of TAGW bits, WORDS×32 data. Storage is register array, asynchronous read.
- Reset (clk edge with reset=1):
  - all valid bits cleared; state=IDLE; refill counter=0; latched address=0.
  - Outputs: hit_out=0, instruction_out=0, busy=0, mem_req=0, mem_addr=0.
  - Data/tag contents are don't-care.
  - Reset aborts a refill in progress. A mem_valid arriving afterwards is ignored.
- States: IDLE, REFILL.
- IDLE:
  - Lookup is combinational, zero-latency: hit_out = req_valid & valid[index] & (tag_store[index]==tag).
  - instruction_out = data[index][word] when hit_out=1, else 0.
  - On req_valid & !hit: latch the line base (req_addr with the low 2+OB bits zeroed), clear valid[index], counter=0, go to REFILL.
- REFILL:
  - busy=1, hit_out=0, instruction_out=0.
  - mem_req=1 with mem_addr = line_base + counter*4. The request is held stable until mem_valid.
  - On mem_valid: write mem_rdata to data[latched index][counter], then counter++.
  - On mem_valid with counter==WORDS-1:
    - write tag and set the valid bit;
    - go to IDLE;
    - mem_req deasserts on the next cycle.
  - mem_valid outside REFILL is ignored.
- Refill latency: exactly WORDS accepted mem_valid beats. The first hit is in the cycle after returning to IDLE, provided req_addr is unchanged. Minimum miss penalty is WORDS+1 cycles when memory has 1-cycle latency.
- req_addr and req_valid changes during REFILL are ignored; the latched address governs the refill. After refill the new req_addr is looked up normally, and may miss again.
- flush:
  - Clears all valid bits on that edge; state goes to IDLE.
  - In REFILL, flush aborts the refill: that line stays invalid and mem_req drops next cycle. A late mem_valid for the aborted request is ignored.
  - flush has priority over a miss detected in the same cycle: no refill starts that cycle.
- reset has priority over flush.
- Address wrap: the refill counter never carries into the index/tag fields. For line base 0xFFFFFFF0 (WORDS=4) the mem_addr sequence is F0, F4, F8, FC.
- Conflict replacement: a miss to a different tag at an occupied index overwrites that line.

Test Plan:
- Reset, then req_valid=1, req_addr=0x0000_0040 (miss). Memory returns 0x11,0x22,0x33,0x44 with 1-cycle latency.
  - Required: mem_addr sequence 0x40, 0x44, 0x48, 0x4C; busy for 4 beats.
  - Then hit_out=1 with instruction_out=0x11. req_addr=0x4C then hits immediately with 0x44.
- Variable latency: memory waits 3 cycles per beat. mem_req and mem_addr must stay stable across the wait cycles.
  - Required: each word is written once; the refill takes 16 cycles.
- Conflict (LINES=16, WORDS=4, so index stride is 0x100): fill 0x040, then request 0x140.
  - Required: 0x140 misses and refills. Re-requesting 0x040 then misses again.
- flush asserted on beat 2 of a refill of 0x080.
  - Required: mem_req=0 on the next cycle; a late mem_valid is ignored. Re-requesting 0x080 restarts the refill at beat 0. Previously valid line 0x040 now misses.
- reset asserted mid-refill.
  - Required: all outputs 0 on the next cycle; all lines miss afterwards.
- req_valid=0 with req_addr at a cached line.
  - Required: hit_out=0 and no mem_req. Changing req_addr during REFILL does not alter the mem_addr sequence.

Source files
------------

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache for the fetch stage.
//
// The lookup is combinational and has zero latency. A miss starts a line
// refill from a word-serial backing memory, and fetch stalls while hit_out
// is low.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   req_valid        fetch presents a valid PC this cycle
//   req_addr         fetch PC (byte address; bits [1:0] are ignored)
//   flush            invalidate all lines and abort any refill
//   hit_out          instruction_out is valid for req_addr
//   instruction_out  instruction word on a hit, otherwise 0
//   busy             a refill is in progress
//   mem_req          read request to backing memory, held until mem_valid
//   mem_addr         word-aligned backing memory read address
//   mem_rdata        backing memory read data
//   mem_valid        mem_rdata is valid and completes the current mem_req
module inst_cache #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        hit_out,
    output logic [31:0] instruction_out,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    localparam int unsigned OB   = $clog2(WORDS);
    localparam int unsigned IB   = $clog2(LINES);
    localparam int unsigned TAGW = 32 - 2 - OB - IB;
    localparam int unsigned LW   = 32 - 2 - OB;  // line address width

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t             state_q;
    logic [LINES-1:0]   valid_q;
    logic [TAGW-1:0]    tag_q  [LINES];
    logic [31:0]        data_q [LINES][WORDS];
    logic [OB-1:0]      cnt_q;
    logic [LW-1:0]      line_q;   // latched line address (req_addr[31:2+OB])

    logic [OB-1:0]      word;
    logic [IB-1:0]      index;
    logic [TAGW-1:0]    tag;
    logic [IB-1:0]      fill_index;
    logic [TAGW-1:0]    fill_tag;
    logic               lookup_hit;
    logic               unused_addr_bits;

    assign word       = req_addr[2+OB-1:2];
    assign index      = req_addr[2+OB+IB-1:2+OB];
    assign tag        = req_addr[31:2+OB+IB];
    assign fill_index = line_q[IB-1:0];
    assign fill_tag   = line_q[LW-1:IB];
    assign unused_addr_bits = ^req_addr[1:0];

    assign lookup_hit = req_valid && valid_q[index] && (tag_q[index] == tag);

    always_comb begin
        hit_out         = 1'b0;
        instruction_out = '0;
        busy            = 1'b0;
        mem_req         = 1'b0;
        mem_addr        = '0;
        if (state_q == IDLE) begin
            hit_out = lookup_hit;
            if (lookup_hit) begin
                instruction_out = data_q[index][word];
            end
        end else begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            // The counter sits below the index field, so beats never carry into it.
            mem_addr = {line_q, cnt_q, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else if (flush) begin
            // Also cancels a miss detected in the same cycle.
            state_q <= IDLE;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && !lookup_hit) begin
                        line_q         <= req_addr[31:2+OB];
                        valid_q[index] <= 1'b0;
                        cnt_q          <= '0;
                        state_q        <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_valid) begin
                        data_q[fill_index][cnt_q] <= mem_rdata;
                        cnt_q                     <= cnt_q + 1'b1;
                        if (cnt_q == OB'(WORDS - 1)) begin
                            tag_q[fill_index]   <= fill_tag;
                            valid_q[fill_index] <= 1'b1;
                            state_q             <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed self-checking bench for inst_cache (LINES=16, WORDS=4).
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        hit_out;
    logic [31:0] instruction_out;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc;

    inst_cache #(.LINES(16), .WORDS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .flush          (flush),
        .hit_out        (hit_out),
        .instruction_out(instruction_out),
        .busy           (busy),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_valid      (mem_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a PC and check the hit flag and the returned word.
    task automatic lookup(input logic [31:0] addr, input logic exp_hit, input logic [31:0] exp_data);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        chk("hit_out", hit_out, exp_hit);
        chk("instruction_out", instruction_out, exp_hit ? exp_data : 32'h0);
    endtask

    // Present a missing PC and take the edge into REFILL.
    task automatic start_miss(input logic [31:0] addr);
        lookup(addr, 1'b0, 32'h0);
        tick();
    endtask

    // Backing memory: lat idle cycles before each beat, then mem_valid with data.
    task automatic serve(input logic [31:0] base, input int unsigned lat,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         output int unsigned ncyc);
        logic [31:0] d [4];
        d = '{d0, d1, d2, d3};
        ncyc = 0;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w <= int'(lat); w++) begin
                mem_valid = (w == int'(lat));
                mem_rdata = mem_valid ? d[b] : 32'h0;
                #1;
                chk("refill_busy", busy, 1'b1);
                chk("refill_mem_req", mem_req, 1'b1);
                chk("refill_mem_addr", mem_addr, base + 32'(4 * b));
                chk("refill_hit_low", hit_out, 1'b0);
                tick();
                ncyc++;
            end
        end
        mem_valid = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        tick();
        tick();
        chk("rst_hit", hit_out, 1'b0);
        chk("rst_instr", instruction_out, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b0;

        // Basic miss with 1-cycle memory, then hits
        start_miss(32'h40);
        serve(32'h40, 0, 32'h11, 32'h22, 32'h33, 32'h44, cyc);
        chk("basic_refill_cycles", cyc, 32'd4);
        chk("basic_idle_busy", busy, 1'b0);
        chk("basic_idle_mem_req", mem_req, 1'b0);
        lookup(32'h40, 1'b1, 32'h11);
        lookup(32'h4C, 1'b1, 32'h44);
        lookup(32'h47, 1'b1, 32'h22);   // byte offset bits ignored

        // Variable latency: 3 wait cycles per beat
        start_miss(32'h200);
        serve(32'h200, 3, 32'hA0, 32'hA1, 32'hA2, 32'hA3, cyc);
        chk("varlat_cycles", cyc, 32'd16);
        lookup(32'h200, 1'b1, 32'hA0);
        lookup(32'h204, 1'b1, 32'hA1);
        lookup(32'h208, 1'b1, 32'hA2);
        lookup(32'h20C, 1'b1, 32'hA3);

        // Conflict at index 4: 0x140 evicts 0x040
        start_miss(32'h140);
        serve(32'h140, 0, 32'hB0, 32'hB1, 32'hB2, 32'hB3, cyc);
        lookup(32'h144, 1'b1, 32'hB1);
        start_miss(32'h40);
        chk("conflict_refetch_busy", busy, 1'b1);
        serve(32'h40, 0, 32'h11, 32'h22, 32'h33, 32'h44, cyc);
        lookup(32'h48, 1'b1, 32'h33);

        // Flush on beat 2 of a refill of 0x080
        start_miss(32'h80);
        serve_partial_flush();
        lookup(32'h80, 1'b0, 32'h0);
        tick();
        chk("flush_restart_addr", mem_addr, 32'h80);
        serve(32'h80, 0, 32'hC0, 32'hC1, 32'hC2, 32'hC3, cyc);
        lookup(32'h8C, 1'b1, 32'hC3);
        lookup(32'h40, 1'b0, 32'h0);
        lookup(32'h200, 1'b0, 32'h0);

        // Reset mid-refill
        start_miss(32'h40);
        mem_valid = 1'b1; mem_rdata = 32'h11; tick();
        mem_valid = 1'b1; mem_rdata = 32'h22; tick();
        mem_valid = 1'b0;
        req_addr = 32'h8C;
        reset = 1'b1;
        tick();
        chk("midrst_hit", hit_out, 1'b0);
        chk("midrst_instr", instruction_out, 32'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        reset = 1'b0;
        req_valid = 1'b0;
        mem_valid = 1'b1; mem_rdata = 32'hDEAD;   // late beat after reset
        tick();
        mem_valid = 1'b0;
        chk("midrst_late_busy", busy, 1'b0);
        lookup(32'h8C, 1'b0, 32'h0);
        lookup(32'h40, 1'b0, 32'h0);

        // req_valid=0 at a cached line
        start_miss(32'h80);
        serve(32'h80, 0, 32'hD0, 32'hD1, 32'hD2, 32'hD3, cyc);
        req_valid = 1'b0;
        req_addr = 32'h84;
        #1;
        chk("noreq_hit", hit_out, 1'b0);
        chk("noreq_instr", instruction_out, 32'h0);
        tick();
        chk("noreq_mem_req", mem_req, 1'b0);
        chk("noreq_busy", busy, 1'b0);

        // Changing req_addr during REFILL leaves the sequence alone
        start_miss(32'h300);
        req_addr = 32'h500;
        req_valid = 1'b0;
        serve(32'h300, 1, 32'hE0, 32'hE1, 32'hE2, 32'hE3, cyc);
        chk("chgaddr_cycles", cyc, 32'd8);
        lookup(32'h500, 1'b0, 32'h0);
        lookup(32'h308, 1'b1, 32'hE2);

        // Top-of-memory line: no carry out of the word field
        start_miss(32'hFFFF_FFF4);
        serve(32'hFFFF_FFF0, 0, 32'hF0, 32'hF4, 32'hF8, 32'hFC, cyc);
        lookup(32'hFFFF_FFFC, 1'b1, 32'hFC);
        lookup(32'hFFFF_FFF0, 1'b1, 32'hF0);

        req_valid = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Beats 0 and 1 of line 0x80, flush on beat 2, then a late mem_valid.
    task automatic serve_partial_flush();
        for (int b = 0; b < 2; b++) begin
            mem_valid = 1'b1;
            mem_rdata = 32'hC0 + 32'(b);
            #1;
            chk("flush_pre_addr", mem_addr, 32'h80 + 32'(4 * b));
            tick();
        end
        mem_valid = 1'b0;
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_beat2_addr", mem_addr, 32'h88);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_mem_req", mem_req, 1'b0);
        chk("flush_busy", busy, 1'b0);
        mem_valid = 1'b1;
        mem_rdata = 32'hBAD0;
        tick();
        mem_valid = 1'b0;
        chk("flush_late_busy", busy, 1'b0);
        chk("flush_late_mem_req", mem_req, 1'b0);
    endtask

endmodule
